// File: rtl/fft_pkg.sv
// Shared constants and types for the 64-point FFT pipeline front end.
// Holds the read-FSM encoding and the packed complex sample.
package fft_pkg;

  localparam int FFT_N         = 64;
  localparam int FFT_LOG2N     = 6;
  localparam int MIN_START_GAP = 185;
  localparam int SAMPLE_DW     = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_GAP
  } rd_state_t;

  typedef struct packed {
    logic signed [SAMPLE_DW-1:0] re;
    logic signed [SAMPLE_DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_in_framer_if.sv
// Valid/ready sample stream feeding the framer; the source drives master,
// the framer takes slave.
interface fft_in_framer_if #(
  parameter int DW = 16
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;

  modport master (output in_valid, output in_re, output in_im, input  in_ready);
  modport slave  (input  in_valid, input  in_re, input  in_im, output in_ready);

endinterface

// File: rtl/fft_in_buf.sv
// Two-bank ping-pong sample store: one write port, one read port with a
// registered output and a bank-select bit.
module fft_in_buf
  import fft_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic                 i_wbank,
  input  logic [FFT_LOG2N-1:0] i_waddr,
  input  logic [2*DW-1:0]      i_wdata,
  input  logic                 i_re,
  input  logic                 i_rbank,
  input  logic [FFT_LOG2N-1:0] i_raddr,
  output logic [2*DW-1:0]      o_rdata
);

  logic [2*DW-1:0] r_mem [2*FFT_N];
  logic [2*DW-1:0] r_rdata;

  // NOTE: the storage and its read register carry no reset; stale contents
  // are never observed because the top gates data with a reset valid flag.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_wbank, i_waddr}] <= i_wdata;
    if (i_re) r_rdata <= r_mem[{i_rbank, i_raddr}];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_in_framer.sv
// Groups accepted samples into 64-sample frames, buffers two frames, and
// replays each one behind a start pulse spaced for the FFT control unit.
module fft_in_framer #(
  parameter int DW            = 16,
  parameter int MIN_START_GAP = fft_pkg::MIN_START_GAP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_in_framer_if.slave        s_in,
  input  logic                  i_flush,
  output logic                  o_start,
  output logic [DW-1:0]         o_data_re,
  output logic [DW-1:0]         o_data_im,
  output logic                  o_data_vld,
  output logic                  o_busy
);
  import fft_pkg::*;

  localparam int                   GW        = $clog2(MIN_START_GAP + 1);
  localparam logic [GW-1:0]        GAP_LOAD  = GW'(MIN_START_GAP - 1);
  localparam logic [FFT_LOG2N-1:0] LAST_ADDR = FFT_LOG2N'(FFT_N - 1);

  logic [FFT_LOG2N-1:0] r_wa;
  logic                 r_wb;
  logic                 r_rb;
  logic [1:0]           r_full;
  logic [1:0]           w_full_nxt;
  rd_state_t            r_state;
  rd_state_t            w_state_nxt;
  logic [FFT_LOG2N:0]   r_cnt;
  logic [GW-1:0]        r_gap;
  logic                 r_start;
  logic                 r_vld;
  logic                 w_xfer;
  logic                 w_fill;
  logic                 w_go;
  logic                 w_rd_en;
  logic                 w_release;
  logic [2*DW-1:0]      w_rdata;

  assign s_in.in_ready = ~r_full[r_wb];
  assign w_xfer    = s_in.in_valid & ~r_full[r_wb] & ~i_flush;
  assign w_fill    = w_xfer & (r_wa == LAST_ADDR);
  assign w_go      = (r_state == S_IDLE) & r_full[r_rb] & (r_gap == '0);
  // r_cnt[6] marks the cycle that drives the last sample and frees the bank.
  assign w_rd_en   = (r_state == S_DRAIN) & ~r_cnt[FFT_LOG2N];
  assign w_release = (r_state == S_DRAIN) &  r_cnt[FFT_LOG2N];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa <= '0;
      r_wb <= 1'b0;
    end else if (i_flush) begin
      r_wa <= '0;
    end else if (w_xfer) begin
      r_wa <= r_wa + 1'b1;
      if (w_fill) r_wb <= ~r_wb;
    end
  end

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a value held, which would infer a latch.
  always_comb begin
    w_full_nxt = r_full;
    if (w_fill)    w_full_nxt[r_wb] = 1'b1;
    if (w_release) w_full_nxt[r_rb] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go)              w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_release)         w_state_nxt = S_GAP;
      // Leave one cycle early so IDLE sees the counter at zero on arrival.
      S_GAP:   if (r_gap <= GW'(1))   w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_full  <= '0;
      r_rb    <= 1'b0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_start <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= w_full_nxt;
      r_start <= w_go;
      r_vld   <= w_rd_en;
      if (w_release) r_rb <= ~r_rb;
      if (w_go)         r_cnt <= '0;
      else if (w_rd_en) r_cnt <= r_cnt + 1'b1;
      if (w_go)               r_gap <= GAP_LOAD;
      else if (r_gap != '0)   r_gap <= r_gap - 1'b1;
    end
  end

  fft_in_buf #(.DW(DW)) u_buf (
    .clk     (clk),
    .i_we    (w_xfer),
    .i_wbank (r_wb),
    .i_waddr (r_wa),
    .i_wdata ({s_in.in_re, s_in.in_im}),
    .i_re    (w_rd_en),
    .i_rbank (r_rb),
    .i_raddr (r_cnt[FFT_LOG2N-1:0]),
    .o_rdata (w_rdata)
  );

  assign o_start    = r_start;
  assign o_data_vld = r_vld;
  assign o_data_re  = r_vld ? w_rdata[2*DW-1:DW] : '0;
  assign o_data_im  = r_vld ? w_rdata[DW-1:0]    : '0;
  // The post-drain spacing wait is not reported as busy.
  assign o_busy     = (|r_full) | (r_state == S_DRAIN);

endmodule
